divider_pipe: RTL
=================

Name: divider_pipe

Overview:
- Next-generation pipelined restoring divider: N-bit dividend by M-bit divisor, one operation accepted per cycle.
- Adds over the previous generation:
  - valid/ready handshake with whole-pipe backpressure,
  - a per-operation tag carried alongside the data,
  - explicit divide-by-zero reporting,
  - optional signed mode.
- Sits between an operand producer and a result consumer in the datapath.

Parameters:
- N, 8, dividend and quotient width (N >= M >= 2)
- M, 4, divisor and remainder width
- TAG_W, 4, width of the user tag carried with each operation

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept; combinationally = !out_valid || out_ready
- in_dividend  in  N  dividend
- in_divisor  in  M  divisor
- in_signed  in  1  per-op signed request (honoured only with the macro)
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_quot  out  N  quotient
- out_rem  out  M  remainder
- out_div0  out  1  divisor was zero
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits, out_valid, out_quot, out_rem, out_div0 and out_tag go to 0;
  - in_ready reads 1 after reset;
  - handshakes while rst is high are ignored;
  - reset mid-operation discards every in-flight op, with no partial output.
- Pipeline structure, N+1 register stages:
  - stage 0 captures operands (magnitudes in signed mode), sign info, the div0 flag and the tag;
  - stages 1..N each resolve one quotient bit, MSB first (trial-subtract shifted divisor; keep or restore);
  - stage N is the output register.
- Global advance: adv = !out_valid || out_ready.
  - When adv=1, every stage shifts forward one position.
  - When adv=0, every stage holds.
  - Bubbles (valid=0) propagate like data.
- Transfer rules:
  - Accept when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - Latency N+1 cycles from accept to out_valid when not stalled.
  - Throughput 1 op/cycle.
- While out_valid=1 and out_ready=0, all out_* signals are stable.
- Unsigned arithmetic:
  - quot = floor(dividend/divisor), rem = dividend - quot*divisor;
  - rem < divisor always fits M bits.
- Divide by zero:
  - out_div0=1, out_quot = all ones, out_rem = dividend[M-1:0];
  - in signed mode the raw dividend bits are used, with no sign fix-up.
- Tag: passed through unmodified, aligned with its result.
- No internal FSM beyond per-stage valid bits. Stall, accept and consume may coincide in one cycle with out_valid=1, out_ready=1, in_valid=1: the result leaves, the pipe shifts and the new op enters, all in that cycle.

Optional Feature:
- Macro: DIVIDER_PIPE_SIGNED_EN.
- Defined:
  - in_signed=1 treats operands as two's complement;
  - division truncates toward zero; remainder takes the dividend's sign;
  - stage 0 stores magnitudes and sign bits; the sign fix-up is applied in the stage N register input;
  - overflow (most-negative / -1) gives quot = most-negative and rem = 0, with out_div0=0.
- Undefined: in_signed is ignored and all operations are unsigned. Port list is identical in both builds.

Decomposition:
- Package divider_pipe_pkg:
  - DIV0_QUOT constant (all ones);
  - stage record field widths (N + M working remainder, tag, sign, div0, valid);
  - helper functions for abs and negate.
- One natural sub-module, divider_pipe_stage: a single trial-subtract/restore stage with a valid bit and hold on !adv. Instantiate it N times via generate.

Test Plan:
All cases use N=8, M=4.
- Unsigned basic: 200/7, tag 3 -> after 9 cycles out_quot=28, out_rem=4, out_div0=0, out_tag=3.
- Divide by zero: 200/0 -> out_quot=0xFF, out_rem=0x8, out_div0=1.
- Backpressure: issue 3 back-to-back ops, then hold out_ready=0 for 5 cycles.
  - in_ready=0 while stalled and outputs stay stable.
  - After release, all 3 results arrive in order, one per cycle, with none lost or duplicated.
- Throughput sweep: all 256 dividends × divisors 1..15 streamed back-to-back with out_ready=1.
  - Scoreboard checks quot*divisor + rem == dividend and rem < divisor.
  - One result per cycle after the initial 9-cycle fill.
- Signed (macro on): -100/7 -> quot=0xF2 (-14), rem=0xE (-2); -128/-1 -> quot=0x80, rem=0, out_div0=0.
- Reset mid-stream: assert rst asynchronously with 5 ops in flight -> out_valid drops immediately; after release no stale results appear; the next op completes normally.

Source files
------------

// File: rtl/divider_pipe_pkg.sv
// divider_pipe_pkg: shared types and helpers for the pipelined divider.
//   ctl_t      per-stage control record (valid, div0, quotient/remainder sign)
//   wide_t     64-bit scratch type used by the width-independent helpers
//   DIV0_QUOT  quotient reported for a zero divisor (all ones, truncated by user)
//   work_w()   width of the working register: remainder (M) + dividend (N)
//   negate()   two's complement negation
//   abs_val()  magnitude of a sign-extended value
package divider_pipe_pkg;

    typedef logic [63:0] wide_t;

    localparam wide_t DIV0_QUOT = '1;

    typedef struct packed {
        logic valid;
        logic div0;
        logic neg_q;
        logic neg_r;
    } ctl_t;

    function automatic int unsigned work_w(input int unsigned n, input int unsigned m);
        return n + m;
    endfunction

    function automatic wide_t negate(input wide_t v);
        return ~v + wide_t'(1);
    endfunction

    // Caller passes a value already sign-extended to 64 bits.
    function automatic wide_t abs_val(input wide_t v);
        return v[63] ? negate(v) : v;
    endfunction

endpackage

// File: rtl/divider_pipe_stage.sv
// divider_pipe_stage: one restoring-division step plus its pipeline register.
// Resolves quotient bit BIT_IDX by trial-subtracting the divisor from the
// partial remainder extended with the next dividend bit. The stage register
// loads on i_adv and holds otherwise; bubbles travel like data.
// When LAST is set this stage is the output register and its input applies the
// divide-by-zero override and, with DIVIDER_PIPE_SIGNED_EN, the sign fix-up.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_adv             pipeline advance
//   i_ctl / o_ctl     control record in / registered out
//   i_work / o_work   {remainder[M], remaining dividend bits[N]}
//   i_quot / o_quot   quotient bits resolved so far
//   i_divisor / o_divisor, i_raw_lo / o_raw_lo, i_tag / o_tag  carried fields
module divider_pipe_stage
    import divider_pipe_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned M       = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned BIT_IDX = 0,
    parameter bit          LAST    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_adv,
    input  ctl_t                     i_ctl,
    input  logic [work_w(N, M)-1:0]  i_work,
    input  logic [N-1:0]             i_quot,
    input  logic [M-1:0]             i_divisor,
    input  logic [M-1:0]             i_raw_lo,
    input  logic [TAG_W-1:0]         i_tag,
    output ctl_t                     o_ctl,
    output logic [work_w(N, M)-1:0]  o_work,
    output logic [N-1:0]             o_quot,
    output logic [M-1:0]             o_divisor,
    output logic [M-1:0]             o_raw_lo,
    output logic [TAG_W-1:0]         o_tag
);

    logic [M:0]   w_trial;
    logic         w_ge;
    logic [M-1:0] w_rem;
    logic [N-1:0] w_quot;
    logic [M-1:0] w_rem_fix;
    logic [N-1:0] w_quot_fix;

    ctl_t                    r_ctl;
    logic [work_w(N, M)-1:0] r_work;
    logic [N-1:0]            r_quot;
    logic [M-1:0]            r_divisor;
    logic [M-1:0]            r_raw_lo;
    logic [TAG_W-1:0]        r_tag;

    // Partial remainder (< divisor) shifted left with the next dividend bit.
    assign w_trial = i_work[N+M-1:N-1];
    assign w_ge    = (w_trial >= {1'b0, i_divisor});

    always_comb begin
        // When w_ge the true difference is < divisor, so M bits are exact.
        w_rem          = w_ge ? (w_trial[M-1:0] - i_divisor) : w_trial[M-1:0];
        w_quot         = i_quot;
        w_quot[BIT_IDX] = w_ge;
    end

    generate
        if (LAST) begin : g_fixup
            always_comb begin
                w_quot_fix = w_quot;
                w_rem_fix  = w_rem;
`ifdef DIVIDER_PIPE_SIGNED_EN
                if (i_ctl.neg_q) w_quot_fix = N'(negate(wide_t'(w_quot)));
                if (i_ctl.neg_r) w_rem_fix  = M'(negate(wide_t'(w_rem)));
`endif
                // Raw dividend bits, never sign-adjusted.
                if (i_ctl.div0) begin
                    w_quot_fix = N'(DIV0_QUOT);
                    w_rem_fix  = i_raw_lo;
                end
            end
        end else begin : g_pass
            assign w_quot_fix = w_quot;
            assign w_rem_fix  = w_rem;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl     <= '0;
            r_work    <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_raw_lo  <= '0;
            r_tag     <= '0;
        end else if (i_adv) begin
            r_ctl     <= i_ctl;
            r_work    <= {w_rem_fix, i_work[N-2:0], 1'b0};
            r_quot    <= w_quot_fix;
            r_divisor <= i_divisor;
            r_raw_lo  <= i_raw_lo;
            r_tag     <= i_tag;
        end
    end

    assign o_ctl     = r_ctl;
    assign o_work    = r_work;
    assign o_quot    = r_quot;
    assign o_divisor = r_divisor;
    assign o_raw_lo  = r_raw_lo;
    assign o_tag     = r_tag;

endmodule

// File: rtl/divider_pipe.sv
// divider_pipe: pipelined restoring divider, N-bit dividend by M-bit divisor,
// one operation per cycle, N+1 register stages with whole-pipe backpressure.
// Stage 0 captures operands (magnitudes in signed mode), signs, div0 and tag;
// stages 1..N each resolve one quotient bit MSB first; stage N is the output.
// Optional macro DIVIDER_PIPE_SIGNED_EN enables per-op signed division
// (in_signed); without it in_signed is ignored.
// Ports:
//   clk, rst                     clock, async active-high reset
//   in_valid / in_ready          operand handshake (in_ready = !out_valid || out_ready)
//   in_dividend, in_divisor      operands
//   in_signed                    per-op signed request
//   in_tag                       user tag, returned with the result
//   out_valid / out_ready        result handshake
//   out_quot, out_rem            quotient, remainder
//   out_div0                     divisor was zero
//   out_tag                      tag of this result
module divider_pipe
    import divider_pipe_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned M     = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_dividend,
    input  logic [M-1:0]     in_divisor,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_quot,
    output logic [M-1:0]     out_rem,
    output logic             out_div0,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned WORK_W = work_w(N, M);

    logic         w_adv;
    logic         w_sgn;
    logic [N-1:0] w_dvd_mag;
    logic [M-1:0] w_dsr_mag;
    ctl_t         w_ctl_in;

    ctl_t              r_ctl0;
    logic [WORK_W-1:0] r_work0;
    logic [M-1:0]      r_dsr0;
    logic [M-1:0]      r_raw_lo0;
    logic [TAG_W-1:0]  r_tag0;

    // Index k holds the outputs of stage k.
    ctl_t              w_ctl    [N+1];
    logic [WORK_W-1:0] w_work   [N+1];
    logic [N-1:0]      w_quot   [N+1];
    logic [M-1:0]      w_dsr    [N+1];
    logic [M-1:0]      w_raw_lo [N+1];
    logic [TAG_W-1:0]  w_tag    [N+1];

    // Every stage moves together; the only stall source is the output.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

`ifdef DIVIDER_PIPE_SIGNED_EN
    assign w_sgn = in_signed;
`else
    logic w_unused_signed;
    assign w_sgn           = 1'b0;
    assign w_unused_signed = in_signed;
`endif

    always_comb begin
        w_dvd_mag      = in_dividend;
        w_dsr_mag      = in_divisor;
        w_ctl_in       = '0;
        w_ctl_in.valid = in_valid;
        w_ctl_in.div0  = (in_divisor == '0);
        w_ctl_in.neg_r = w_sgn & in_dividend[N-1];
        w_ctl_in.neg_q = w_sgn & (in_dividend[N-1] ^ in_divisor[M-1]);
        if (w_sgn) begin
            // Most-negative values map to 2^(W-1), still representable unsigned.
            w_dvd_mag = N'(abs_val(wide_t'($signed(in_dividend))));
            w_dsr_mag = M'(abs_val(wide_t'($signed(in_divisor))));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl0    <= '0;
            r_work0   <= '0;
            r_dsr0    <= '0;
            r_raw_lo0 <= '0;
            r_tag0    <= '0;
        end else if (w_adv) begin
            r_ctl0    <= w_ctl_in;
            r_work0   <= {{M{1'b0}}, w_dvd_mag};
            r_dsr0    <= w_dsr_mag;
            r_raw_lo0 <= in_dividend[M-1:0];
            r_tag0    <= in_tag;
        end
    end

    assign w_ctl[0]    = r_ctl0;
    assign w_work[0]   = r_work0;
    assign w_quot[0]   = '0;
    assign w_dsr[0]    = r_dsr0;
    assign w_raw_lo[0] = r_raw_lo0;
    assign w_tag[0]    = r_tag0;

    generate
        for (genvar k = 1; k <= N; k++) begin : g_stage
            divider_pipe_stage #(
                .N       (N),
                .M       (M),
                .TAG_W   (TAG_W),
                .BIT_IDX (N - k),
                .LAST    (k == N)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .i_adv     (w_adv),
                .i_ctl     (w_ctl[k-1]),
                .i_work    (w_work[k-1]),
                .i_quot    (w_quot[k-1]),
                .i_divisor (w_dsr[k-1]),
                .i_raw_lo  (w_raw_lo[k-1]),
                .i_tag     (w_tag[k-1]),
                .o_ctl     (w_ctl[k]),
                .o_work    (w_work[k]),
                .o_quot    (w_quot[k]),
                .o_divisor (w_dsr[k]),
                .o_raw_lo  (w_raw_lo[k]),
                .o_tag     (w_tag[k])
            );
        end
    endgenerate

    assign out_valid = w_ctl[N].valid;
    assign out_div0  = w_ctl[N].div0;
    assign out_quot  = w_quot[N];
    assign out_rem   = w_work[N][WORK_W-1:N];
    assign out_tag   = w_tag[N];

    logic w_unused_tail;
    assign w_unused_tail = ^{w_ctl[N].neg_q, w_ctl[N].neg_r, w_work[N][N-1:0],
                             w_dsr[N], w_raw_lo[N]};

endmodule
